// File: rtl/instruction_fetch_if.sv
// Fetch-to-ROM/decode bundle: ROM address/data, redirect request and the decode valid/ready handshake.
// The master modport is the fetch unit; slave is the ROM/decode/control side.
interface instruction_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic                  ready_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic [31:0]           fetch_count_o;
  logic                  fault_o;

  modport master (
    output rom_addr_o, valid_o, instr_o, pc_o, fetch_count_o, fault_o,
    input  rom_data_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  rom_addr_o, valid_o, instr_o, pc_o, fetch_count_o, fault_o,
    output rom_data_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC generation and single-slot fetch stage in front of a combinational program ROM.
// Define FETCH_BOUNDS_CHECK_EN to halt with a sticky fault on out-of-range fetches.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = 32'h0040_0000
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] ADDR_MASK  = DATA_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN
`ifdef FETCH_BOUNDS_CHECK_EN
    , ST_HALT
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]           count_q, count_d;

  logic [DATA_WIDTH-1:0] word_index;
  logic [DATA_WIDTH-1:0] target;
  logic                  handshake;
  logic                  slot_free;

  assign word_index = (pc_q - PC_RESET) >> 2;
  assign target     = bus.redirect_pc_i & ALIGN_MASK;
  assign handshake  = valid_q && bus.ready_i;
  assign slot_free  = !valid_q || bus.ready_i;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] target_index;
  logic                  fetch_in_range;
  logic                  target_in_range;

  assign target_index    = (target - PC_RESET) >> 2;
  assign fetch_in_range  = (pc_q >= PC_RESET) && (word_index < DATA_WIDTH'(MEMORY_DEPTH));
  assign target_in_range = (target >= PC_RESET) && (target_index < DATA_WIDTH'(MEMORY_DEPTH));
  assign bus.fault_o     = fault_q;
`else
  assign bus.fault_o     = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted to its register first so no
    // path through the case below can leave a variable unassigned (no latches).
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    count_d  = count_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d  = fault_q;
`endif

    // A handshake in the same cycle as a redirect still counts.
    if (handshake) count_d = count_q + 32'd1;

    if (bus.redirect_i) begin
      pc_d    = target;
      valid_d = 1'b0;
      case (state_q)
`ifdef FETCH_BOUNDS_CHECK_EN
        ST_HALT: begin
          if (target_in_range) begin
            fault_d = 1'b0;
            state_d = ST_RUN;
          end
        end
`endif
        default: state_d = ST_RUN;
      endcase
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (slot_free) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (!fetch_in_range) begin
              fault_d = 1'b1;
              state_d = ST_HALT;
              valid_d = 1'b0;
            end else
`endif
            begin
              instr_d  = bus.rom_data_i;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + PC_STEP;
            end
          end
        end
        default: valid_d = valid_q && !bus.ready_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; the reset branch wins over redirect and stall.
    if (!reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= PC_RESET;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      count_q  <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      count_q  <= count_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  assign bus.rom_addr_o    = word_index & ADDR_MASK;
  assign bus.valid_o       = valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_out_q;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: boot, streaming, stall, redirect, word-31 boundary
// and mid-stream reset. The ROM model returns 0x1000_0000 + word index.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] ROMV = 32'h1000_0000;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  instruction_fetch_if #(.DATA_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .PC_RESET    (BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.rom_data_i = ROMV + bus.rom_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    check({tag, ".pc"}, bus.pc_o, pc);
    check({tag, ".instr"}, bus.instr_o, ROMV + ((pc - BASE) >> 2) % 32);
    check({tag, ".count"}, bus.fetch_count_o, cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, ".instr"}, bus.instr_o, 32'd0);
    check({tag, ".pc"}, bus.pc_o, 32'd0);
    check({tag, ".count"}, bus.fetch_count_o, 32'd0);
    check({tag, ".fault"}, 32'(bus.fault_o), 32'd0);
    check({tag, ".addr"}, bus.rom_addr_o, 32'd0);
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    reset             = 1'b0;
    bus.ready_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    step();
    step();
    check_reset_vals("reset");

    // Boot: first edge BOOT->RUN, second edge delivers word 0.
    reset       = 1'b1;
    bus.ready_i = 1'b1;
    step();
    check("boot_edge1.valid", 32'(bus.valid_o), 32'd0);
    step();
    check_out("first", BASE, 32'd0);
    step();
    check_out("stream1", BASE + 32'd4, 32'd1);
    step();
    check_out("stream2", BASE + 32'd8, 32'd2);

    // Stall three cycles on 0x0040_0008.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stall%0d", i), BASE + 32'd8, 32'd2);
    end
    bus.ready_i = 1'b1;
    step();
    check_out("release", BASE + 32'h0C, 32'd3);
    for (int k = 4; k <= 8; k++) begin
      step();
      check_out($sformatf("stream%0d", k), BASE + 32'(4 * k), 32'(k));
    end

    // Redirect while stalled on 0x0040_0020: target low bits dropped, one bubble.
    bus.ready_i = 1'b0;
    step();
    check_out("stall_pre_redir", BASE + 32'h20, 32'd8);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0043;
    step();
    check("redir.valid", 32'(bus.valid_o), 32'd0);
    check("redir.addr", bus.rom_addr_o, 32'd16);
    check("redir.count", bus.fetch_count_o, 32'd8);
    bus.redirect_i = 1'b0;
    bus.ready_i    = 1'b1;
    step();
    check_out("redir_target", BASE + 32'h40, 32'd8);

    // Redirect coinciding with a handshake: the dropped word still counts.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0070;
    step();
    check("redir_hs.valid", 32'(bus.valid_o), 32'd0);
    check("redir_hs.count", bus.fetch_count_o, 32'd9);
    check("redir_hs.addr", bus.rom_addr_o, 32'd28);
    bus.redirect_i = 1'b0;
    step();
    check_out("w28", BASE + 32'h70, 32'd9);
    step();
    check_out("w29", BASE + 32'h74, 32'd10);
    step();
    check_out("w30", BASE + 32'h78, 32'd11);
    step();
    check_out("w31", BASE + 32'h7C, 32'd12);
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("oob.fault", 32'(bus.fault_o), 32'd1);
    check("oob.valid", 32'(bus.valid_o), 32'd0);
    check("oob.count", bus.fetch_count_o, 32'd13);
    step();
    check("halt.fault", 32'(bus.fault_o), 32'd1);
    check("halt.valid", 32'(bus.valid_o), 32'd0);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0100;
    step();
    check("halt_bad_redir.fault", 32'(bus.fault_o), 32'd1);
    bus.redirect_pc_i = BASE;
    step();
    check("recover.fault", 32'(bus.fault_o), 32'd0);
    check("recover.valid", 32'(bus.valid_o), 32'd0);
    bus.redirect_i = 1'b0;
    step();
    check_out("resume", BASE, 32'd13);
`else
    check_out("wrap", BASE + 32'h80, 32'd13);
    check("wrap.fault", 32'(bus.fault_o), 32'd0);
    step();
    check_out("wrap_next", BASE + 32'h84, 32'd14);
`endif

    // Reset mid-stream with a redirect pending: reset wins.
    reset             = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0010;
    step();
    check_reset_vals("midreset");
    reset          = 1'b1;
    bus.redirect_i = 1'b0;
    step();
    check("reboot_edge1.valid", 32'(bus.valid_o), 32'd0);
    step();
    check_out("reboot_first", BASE, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and fetch stage that sits directly upstream of the single-port program ROM. It generates the ROM word address and captures the combinational instruction word. It then presents `{pc, instruction}` to the decode stage over a valid/ready handshake. Branch and jump redirects flush the fetch slot.

## Interface
- `DATA_WIDTH`, 32: instruction, PC and address width.
- `MEMORY_DEPTH`, 32: ROM depth in words; must be a power of two.
- `PC_RESET`, 32'h0040_0000: byte address of the first instruction (ROM word 0).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `rom_addr_o` output DATA_WIDTH: word index into ROM, drives ROM `addr`.
- `rom_data_i` input DATA_WIDTH: ROM `q`, combinational, valid in the same cycle as `rom_addr_o`.
- `redirect_i` input 1: load a new PC; flushes the fetch slot.
- `redirect_pc_i` input DATA_WIDTH: redirect target byte address.
- `ready_i` input 1: decode stage accepts `instr_o` this cycle.
- `valid_o` output 1: `instr_o`/`pc_o` hold a fetched instruction.
- `instr_o` output DATA_WIDTH: fetched instruction.
- `pc_o` output DATA_WIDTH: byte address of `instr_o`.
- `fetch_count_o` output 32: number of instructions accepted by decode (handshakes), wraps at 2^32.
- `fault_o` output 1: out-of-range fetch; only with the macro, otherwise tied 0.

## Operation
- Internal `pc` holds the byte address of the next instruction to fetch. `redirect_pc_i[1:0]` is forced to 0 on load.
- `rom_addr_o` = ((pc − PC_RESET) >> 2) mod MEMORY_DEPTH, combinational from `pc`.
- States: BOOT, RUN, HALT (HALT exists only with the macro).
- BOOT: entered on reset; no fetch. Next edge goes to RUN, or to RUN with `pc` = target if `redirect_i` is asserted.
- RUN, slot free (`!valid_o` or `ready_i`):
  - Capture `rom_data_i` into `instr_o` and `pc` into `pc_o`.
  - Set `valid_o` = 1.
  - `pc` += 4, 32-bit wrap.
- RUN, stall (`valid_o && !ready_i`): `instr_o`, `pc_o`, `valid_o` and `pc` hold.
- Handshake: `valid_o && ready_i` at an edge increments `fetch_count_o`. `valid_o` never drops without a handshake, except on redirect or reset.
- Redirect (any state): it has priority over capture and stall.
  - `pc` = target and `valid_o` = 0 at the next edge; the held instruction is discarded.
  - If the discarded instruction was handshaken in that same cycle (`valid_o && ready_i`), it still counts.
  - In HALT with an in-range target: `fault_o` clears and the state goes to RUN.

## Timing
- Reset values: `valid_o` = 0, `instr_o` = 0, `pc_o` = 0, `fetch_count_o` = 0, `fault_o` = 0, `pc` = PC_RESET (so `rom_addr_o` = 0), state BOOT.
- After reset deasserts: the first edge is BOOT→RUN. `valid_o` first rises after the second edge, with `pc_o` = PC_RESET.
- Throughput: one instruction per cycle while `ready_i` = 1; zero bubbles.
- Redirect latency: exactly one bubble cycle.
  - At edge N, `redirect_i` = 1.
  - After edge N, `valid_o` = 0.
  - After edge N+1, `valid_o` = 1 with `pc_o` = target.
- Reset asserted mid-operation forces all reset values at that edge, regardless of stall or redirect.

## Configuration
- `FETCH_BOUNDS_CHECK_EN` defined:
  - A RUN capture attempt with `pc` < PC_RESET or word index ≥ MEMORY_DEPTH performs no capture.
  - It sets `fault_o` = 1 (sticky) and enters HALT.
  - An instruction already held stays valid until handshaken.
  - HALT leaves only via reset or a redirect to an in-range target. A redirect to an out-of-range target keeps HALT and `fault_o`.
- Not defined: no HALT state and `fault_o` = 0. The address wraps modulo MEMORY_DEPTH and fetching continues indefinitely.

## Test plan
- Reset, then `ready_i` = 1 with ROM word k = 0x1000_0000+k:
  - `valid_o` first rises on the second edge after reset release.
  - `pc_o` = 0x0040_0000, 0x0040_0004, … with `instr_o` = 0x1000_0000, 0x1000_0001, …
  - `fetch_count_o` = 8 after 8 handshakes.
- Drop `ready_i` for 3 cycles while `pc_o` = 0x0040_0008: `instr_o`, `pc_o` and `fetch_count_o` hold. On release the next `pc_o` is 0x0040_000C, with no skipped or duplicated instruction.
- `redirect_i` with target 0x0040_0043 while stalled: next cycle `valid_o` = 0 and the held instruction is dropped. The cycle after, `pc_o` = 0x0040_0040 and `rom_addr_o` was 16.
- Run past word 31:
  - With the macro: `pc_o` 0x0040_007C is delivered, then `fault_o` = 1 and `valid_o` = 0. Redirect to 0x0040_0000 clears the fault and resumes at word 0.
  - Without the macro: `pc_o` = 0x0040_0080 carries word 0.
- Assert `reset` low mid-stream with a redirect pending: at that edge all outputs take reset values. The BOOT sequence then repeats, starting at PC_RESET.
